// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int calc_max_val(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running bit-period divider: counts 0..MAX_VAL-1, ticks on the last count, clears on clr_i.
module uart_baud_gen #(
    parameter int MAX_VAL  = 5208,
    parameter int DC_WIDTH = $clog2(MAX_VAL) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    logic [DC_WIDTH-1:0] cnt;

    assign tick_o = (cnt == DC_WIDTH'(MAX_VAL - 1));

    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            cnt <= '0;
        end else if (tick_o) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: serialises a latched word LSB-first as start, data, optional parity, stop bit(s).
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int F_SIZE    = 8,
    parameter int CLK_FREQ  = 50000000,
    parameter int FREQ      = 9600,
    parameter int MAX_VAL   = calc_max_val(CLK_FREQ, FREQ),
    parameter int DC_WIDTH  = $clog2(MAX_VAL) + 1,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [F_SIZE-1:0] tx_data,
    output logic              tx,
    output logic              busy_o,
    output logic              end_o
);

    localparam int BC_W = 4;

    state_t            state;
    logic [F_SIZE-1:0] shift_q;
    logic [F_SIZE-1:0] data_q;
    logic [BC_W-1:0]   bit_cnt;
    logic              tick;
    logic              baud_clr;

    // Holding the divider clear in IDLE gives every frame a full-length start bit.
    assign baud_clr = (state == IDLE);

    uart_baud_gen #(
        .MAX_VAL (MAX_VAL),
        .DC_WIDTH(DC_WIDTH)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clr_i (baud_clr),
        .tick_o(tick)
    );

    function automatic logic parity_bit(input logic [F_SIZE-1:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ^d;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy_o  <= 1'b0;
            end_o   <= 1'b0;
            bit_cnt <= '0;
            shift_q <= '0;
            data_q  <= '0;
        end else begin
            end_o <= 1'b0;
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    busy_o  <= 1'b0;
                    bit_cnt <= '0;
                    if (start_i) begin
                        shift_q <= tx_data;
                        data_q  <= tx_data;
                        state   <= START;
                        tx      <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        tx    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt == BC_W'(F_SIZE - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                state <= uart_pkg::PARITY;
                                tx    <= parity_bit(data_q);
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                            tx      <= shift_q[1];
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
                STOP: begin
                    // bit_cnt is reused here to count stop bits.
                    if (tick) begin
                        if (bit_cnt == BC_W'(STOP_BITS - 1)) begin
                            state   <= IDLE;
                            busy_o  <= 1'b0;
                            end_o   <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    busy_o  <= 1'b0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: four configurations driven in parallel against a bit-table model.
module tb_uart_tx_fsm;

    localparam int MV = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [7:0] tx_data;
    logic [3:0] tx_w, busy_w, end_w;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // cfg0: no parity/1 stop, cfg1: even, cfg2: odd, cfg3: no parity/2 stops
    uart_tx_fsm #(.F_SIZE(8), .CLK_FREQ(160), .FREQ(10), .PARITY(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .rst(rst), .start_i(start_i), .tx_data(tx_data),
        .tx(tx_w[0]), .busy_o(busy_w[0]), .end_o(end_w[0]));
    uart_tx_fsm #(.F_SIZE(8), .CLK_FREQ(160), .FREQ(10), .PARITY(1), .STOP_BITS(1)) dut_e (
        .clk(clk), .rst(rst), .start_i(start_i), .tx_data(tx_data),
        .tx(tx_w[1]), .busy_o(busy_w[1]), .end_o(end_w[1]));
    uart_tx_fsm #(.F_SIZE(8), .CLK_FREQ(160), .FREQ(10), .PARITY(2), .STOP_BITS(1)) dut_o (
        .clk(clk), .rst(rst), .start_i(start_i), .tx_data(tx_data),
        .tx(tx_w[2]), .busy_o(busy_w[2]), .end_o(end_w[2]));
    uart_tx_fsm #(.F_SIZE(8), .CLK_FREQ(160), .FREQ(10), .PARITY(0), .STOP_BITS(2)) dut_s2 (
        .clk(clk), .rst(rst), .start_i(start_i), .tx_data(tx_data),
        .tx(tx_w[3]), .busy_o(busy_w[3]), .end_o(end_w[3]));

    function automatic int cfg_par(input int c);
        return (c == 1) ? 1 : (c == 2) ? 2 : 0;
    endfunction

    function automatic int cfg_stop(input int c);
        return (c == 3) ? 2 : 1;
    endfunction

    function automatic int flen(input int c);
        return MV * (1 + 8 + ((cfg_par(c) != 0) ? 1 : 0) + cfg_stop(c));
    endfunction

    // Line level j cycles after the accept edge, from the frame's bit list.
    function automatic logic frame_bit(input int c, input logic [7:0] d, input int j);
        int b;
        int ones;
        if (j < 0 || j >= flen(c)) return 1'b1;
        b = j / MV;
        ones = $countones(d);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (cfg_par(c) == 1 && b == 9) return (ones % 2) == 1;
        if (cfg_par(c) == 2 && b == 9) return (ones % 2) == 0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        start_i = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            tx_data = 8'($urandom);
            if (j == 3) begin
                rst = 1'b1;
                start_i = 1'b0;
            end
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (tx_w[c] !== 1'b1) $display("FAIL reset_tx cfg%0d cyc%0d got %b exp 1", c, j, tx_w[c]);
                else passed++;
                checks++;
                if (busy_w[c] !== 1'b0) $display("FAIL reset_busy cfg%0d cyc%0d got %b exp 0", c, j, busy_w[c]);
                else passed++;
                checks++;
                if (end_w[c] !== 1'b0) $display("FAIL reset_end cfg%0d cyc%0d got %b exp 0", c, j, end_w[c]);
                else passed++;
            end
        end
    endtask

    // One frame; tx_data is scrambled every cycle after acceptance.
    task automatic test_frame(input logic [7:0] d);
        @(negedge clk);
        start_i = 1'b1;
        tx_data = d;
        for (int j = 0; j <= 176 + 8; j++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (tx_w[c] !== frame_bit(c, d, j))
                    $display("FAIL frame_tx cfg%0d data %h cyc%0d got %b exp %b", c, d, j, tx_w[c], frame_bit(c, d, j));
                else passed++;
                checks++;
                if (busy_w[c] !== (j < flen(c)))
                    $display("FAIL frame_busy cfg%0d data %h cyc%0d got %b exp %b", c, d, j, busy_w[c], j < flen(c));
                else passed++;
                checks++;
                if (end_w[c] !== (j == flen(c)))
                    $display("FAIL frame_end cfg%0d data %h cyc%0d got %b exp %b", c, d, j, end_w[c], j == flen(c));
                else passed++;
            end
            start_i = 1'b0;
            tx_data = 8'($urandom);
        end
    endtask

    task automatic test_busy_protect();
        logic [7:0] d;
        d = 8'h0F;
        @(negedge clk);
        start_i = 1'b1;
        tx_data = d;
        for (int j = 0; j <= 176 + 40; j++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (tx_w[c] !== frame_bit(c, d, j))
                    $display("FAIL busy_tx cfg%0d cyc%0d got %b exp %b", c, j, tx_w[c], frame_bit(c, d, j));
                else passed++;
                checks++;
                if (busy_w[c] !== (j < flen(c)))
                    $display("FAIL busy_busy cfg%0d cyc%0d got %b exp %b", c, j, busy_w[c], j < flen(c));
                else passed++;
                checks++;
                if (end_w[c] !== (j == flen(c)))
                    $display("FAIL busy_end cfg%0d cyc%0d got %b exp %b", c, j, end_w[c], j == flen(c));
                else passed++;
            end
            start_i = (j >= 30 && j < 100);
            tx_data = 8'hFF;
        end
        start_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  L;
        logic etx, ebusy, eend;
        @(negedge clk);
        start_i = 1'b1;
        tx_data = 8'h01;
        for (int j = 0; j <= 2 * 176 + 10; j++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                L = flen(c);
                if (j < L) etx = frame_bit(c, 8'h01, j);
                else if (j == L) etx = 1'b1;
                else etx = frame_bit(c, 8'h80, j - L - 1);
                ebusy = (j < L) || (j > L && j < 2 * L + 1);
                eend  = (j == L) || (j == 2 * L + 1);
                checks++;
                if (tx_w[c] !== etx) $display("FAIL b2b_tx cfg%0d cyc%0d got %b exp %b", c, j, tx_w[c], etx);
                else passed++;
                checks++;
                if (busy_w[c] !== ebusy) $display("FAIL b2b_busy cfg%0d cyc%0d got %b exp %b", c, j, busy_w[c], ebusy);
                else passed++;
                checks++;
                if (end_w[c] !== eend) $display("FAIL b2b_end cfg%0d cyc%0d got %b exp %b", c, j, end_w[c], eend);
                else passed++;
            end
            tx_data = 8'h80;
            if (j == 179) start_i = 1'b0;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic etx, ebusy;
        d = 8'($urandom);
        @(negedge clk);
        start_i = 1'b1;
        tx_data = d;
        for (int j = 0; j <= 200; j++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                etx   = (j <= 68) ? frame_bit(c, d, j) : 1'b1;
                ebusy = (j <= 68);
                checks++;
                if (tx_w[c] !== etx) $display("FAIL rstmid_tx cfg%0d cyc%0d got %b exp %b", c, j, tx_w[c], etx);
                else passed++;
                checks++;
                if (busy_w[c] !== ebusy) $display("FAIL rstmid_busy cfg%0d cyc%0d got %b exp %b", c, j, busy_w[c], ebusy);
                else passed++;
                checks++;
                if (end_w[c] !== 1'b0) $display("FAIL rstmid_end cfg%0d cyc%0d got %b exp 0", c, j, end_w[c]);
                else passed++;
            end
            start_i = 1'b0;
            if (j == 68) rst = 1'b0;
            if (j == 72) rst = 1'b1;
        end
        test_frame(8'($urandom));
    endtask

    initial begin
        rst = 1'b0;
        start_i = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_frame(8'h55);
        test_frame(8'hA3);
        test_frame(8'h00);
        test_frame(8'hFF);
        for (int k = 0; k < 5; k++) test_frame(8'($urandom));
        test_busy_protect();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
